// File: rtl/imem_boot_loader.sv
// Boot loader: fills the instruction RAM from a byte stream, then hands the RAM port to the CPU fetch.
// Optional checksum byte after the payload is enabled with `define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    input  logic              StartLoad,
    input  logic [31:0]       CpuPC,
    output logic [31:0]       Instruction,
    output logic              CpuHold,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [31:0]       RamWData,
    output logic              RamWE,
    input  logic [31:0]       RamRData,
    output logic              LoadDone,
    output logic              LoadError,
    output logic [LEN_W-1:0]  WordCount
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHECK, S_RUN, S_ERR
    } state_t;
    localparam state_t LOAD_END = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_RUN, S_ERR
    } state_t;
    localparam state_t LOAD_END = S_RUN;
`endif

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state, state_next;
    logic [LEN_W-1:0]  word_count;
    logic [1:0]        byte_idx;
    logic [31:0]       shift;
    logic [15:0]       header;
    logic              accept;
    logic [15:0]       hdr_full;
    logic [31:0]       count_inc;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        sum_final;
`endif

    assign accept    = RxValid & RxReady;
    assign hdr_full  = {header[15:8], RxData};
    assign count_inc = 32'(word_count) + 32'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign sum_final = sum + RxData;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (StartLoad) begin
            state_next = S_HDR_HI;
        end else begin
            case (state)
                S_HDR_HI: if (accept) state_next = S_HDR_LO;
                S_HDR_LO: begin
                    if (accept) begin
                        if (hdr_full == 16'd0)
                            state_next = LOAD_END;
                        else if (32'(hdr_full) > DEPTH)
                            state_next = S_ERR;
                        else
                            state_next = S_DATA;
                    end
                end
                S_DATA: if (accept && byte_idx == 2'd3) state_next = S_WRITE;
                S_WRITE: state_next = (count_inc == 32'(header)) ? LOAD_END : S_DATA;
`ifdef IMEM_BOOT_CHECKSUM_EN
                S_CHECK: if (accept) state_next = (sum_final == 8'd0) ? S_RUN : S_ERR;
`endif
                default: state_next = state;
            endcase
        end
    end

    // StartLoad has priority: a byte accepted in the same cycle is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            header     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum        <= '0;
`endif
        end else if (StartLoad) begin
            word_count <= '0;
            byte_idx   <= '0;
            header     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            case (state)
                S_HDR_HI: if (accept) header[15:8] <= RxData;
                S_HDR_LO: if (accept) header[7:0] <= RxData;
                S_DATA: begin
                    if (accept) begin
                        shift    <= {shift[23:0], RxData};
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        sum      <= sum + RxData;
`endif
                    end
                end
                S_WRITE: word_count <= word_count + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        RxReady     = 1'b0;
        CpuHold     = 1'b1;
        LoadDone    = 1'b0;
        LoadError   = 1'b0;
        RamWE       = 1'b0;
        RamAddr     = word_count[ADDR_W-1:0];
        RamWData    = shift;
        Instruction = '0;
        case (state)
            S_HDR_HI, S_HDR_LO, S_DATA: RxReady = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK: RxReady = 1'b1;
`endif
            S_WRITE: RamWE = 1'b1;
            S_RUN: begin
                CpuHold     = 1'b0;
                LoadDone    = 1'b1;
                RamAddr     = CpuPC[ADDR_W+1:2];
                Instruction = RamRData;
            end
            S_ERR: LoadError = 1'b1;
            default: ;
        endcase
    end

    assign WordCount = word_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a behavioural RAM and a write log.
// Define IMEM_BOOT_CHECKSUM_EN for both files to exercise the checksum build.
module tb_imem_boot_loader;
    logic        clk;
    logic        reset;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        StartLoad;
    logic [31:0] CpuPC;
    logic [31:0] Instruction;
    logic        CpuHold;
    logic [7:0]  RamAddr;
    logic [31:0] RamWData;
    logic        RamWE;
    logic [31:0] RamRData;
    logic        LoadDone;
    logic        LoadError;
    logic [15:0] WordCount;

    int checks;
    int failures;

    logic [31:0] mem [256];
    logic [7:0]  wq_addr [$];
    logic [31:0] wq_data [$];

    imem_boot_loader #(.ADDR_W(8), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .StartLoad(StartLoad), .CpuPC(CpuPC),
        .Instruction(Instruction), .CpuHold(CpuHold), .RamAddr(RamAddr),
        .RamWData(RamWData), .RamWE(RamWE), .RamRData(RamRData),
        .LoadDone(LoadDone), .LoadError(LoadError), .WordCount(WordCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign RamRData = mem[RamAddr];

    always @(posedge clk) begin
        if (RamWE === 1'b1) begin
            mem[RamAddr] <= RamWData;
            wq_addr.push_back(RamAddr);
            wq_data.push_back(RamWData);
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) @(negedge clk);
        RxData  = b;
        RxValid = 1'b1;
        n = 0;
        while (RxReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (RxReady !== 1'b1) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%02h RxReady=%b required=1", b, RxReady);
        end
        @(negedge clk);
        RxValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic finish_load(input logic [7:0] c);
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_byte(c, 0);
`else
        if (c == 8'hFF) $display("note: unused checksum byte");
`endif
    endtask

    task automatic pulse_start();
        StartLoad = 1'b1;
        @(negedge clk);
        StartLoad = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        checks++;
        if ({CpuHold, RxReady, RamWE, LoadDone, LoadError} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=11000", {CpuHold, RxReady, RamWE, LoadDone, LoadError});
        end
        checks++;
        if (WordCount !== 16'd0 || Instruction !== 32'd0) begin
            failures++;
            $display("FAIL reset_values wc=%0d instr=%h required 0/0", WordCount, Instruction);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        CpuPC = 32'h0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h241A0001, 0);
        checks++;
        if (RamWE !== 1'b1 || RamAddr !== 8'd0 || RamWData !== 32'h241A0001 || CpuHold !== 1'b1) begin
            failures++;
            $display("FAIL single_write we=%b addr=%h data=%h hold=%b required 1/00/241a0001/1", RamWE, RamAddr, RamWData, CpuHold);
        end
        @(negedge clk);
        finish_load(8'hC1);
        checks++;
        if (CpuHold !== 1'b0 || LoadDone !== 1'b1 || RamWE !== 1'b0 || WordCount !== 16'd1) begin
            failures++;
            $display("FAIL single_run hold=%b done=%b we=%b wc=%0d required 0/1/0/1", CpuHold, LoadDone, RamWE, WordCount);
        end
        #1;
        checks++;
        if (Instruction !== 32'h241A0001) begin
            failures++;
            $display("FAIL single_fetch instr=%h required 241a0001", Instruction);
        end
        checks++;
        if (wq_addr.size() != 1) begin
            failures++;
            $display("FAIL single_write_count got=%0d required 1", wq_addr.size());
        end
    endtask

    task automatic test_multi_word();
        logic [31:0] words [3];
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        checks++;
        if (CpuHold !== 1'b1 || LoadDone !== 1'b0 || WordCount !== 16'd0) begin
            failures++;
            $display("FAIL restart_state hold=%b done=%b wc=%0d required 1/0/0", CpuHold, LoadDone, WordCount);
        end
        CpuPC = 32'h00000008;
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(words[0], 0);
        send_word(words[1], 0);
        #1;
        checks++;
        if (Instruction !== 32'd0 || RamAddr !== 8'd1) begin
            failures++;
            $display("FAIL preload_nop instr=%h addr=%h required 0/01", Instruction, RamAddr);
        end
        @(negedge clk);
        send_word(words[2], 0);
        @(negedge clk);
        finish_load(8'h68);
        checks++;
        if (wq_addr.size() != 3) begin
            failures++;
            $display("FAIL multi_write_count got=%0d required 3", wq_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq_addr[i] !== 8'(i) || wq_data[i] !== words[i]) begin
                    failures++;
                    $display("FAIL multi_write%0d addr=%h data=%h required %h/%h", i, wq_addr[i], wq_data[i], i, words[i]);
                end
            end
        end
        #1;
        checks++;
        if (LoadDone !== 1'b1 || RamAddr !== 8'd2 || Instruction !== 32'h33333333) begin
            failures++;
            $display("FAIL fetch_pc8 done=%b addr=%h instr=%h required 1/02/33333333", LoadDone, RamAddr, Instruction);
        end
        CpuPC = 32'h00400404;
        #1;
        checks++;
        if (RamAddr !== 8'd1 || Instruction !== 32'h22222222) begin
            failures++;
            $display("FAIL fetch_upper_ignored addr=%h instr=%h required 01/22222222", RamAddr, Instruction);
        end
        @(negedge clk);
    endtask

    task automatic test_oversize_header();
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (LoadError !== 1'b1 || RxReady !== 1'b0 || CpuHold !== 1'b1 || LoadDone !== 1'b0) begin
            failures++;
            $display("FAIL oversize_err err=%b rdy=%b hold=%b done=%b required 1/0/1/0", LoadError, RxReady, CpuHold, LoadDone);
        end
        pulse_start();
        checks++;
        if (LoadError !== 1'b0 || RxReady !== 1'b1) begin
            failures++;
            $display("FAIL err_restart err=%b rdy=%b required 0/1", LoadError, RxReady);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        finish_load(8'h00);
        checks++;
        if (LoadDone !== 1'b1 || CpuHold !== 1'b0 || wq_addr.size() != 0) begin
            failures++;
            $display("FAIL empty_load done=%b hold=%b writes=%0d required 1/0/0", LoadDone, CpuHold, wq_addr.size());
        end
    endtask

    task automatic test_gaps_and_drop();
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send_byte(8'h00, int'($urandom_range(0, 7)));
        send_byte(8'h01, int'($urandom_range(0, 7)));
        send_byte(8'h24, int'($urandom_range(0, 7)));
        RxData    = 8'h1A;
        RxValid   = 1'b1;
        StartLoad = 1'b1;
        @(negedge clk);
        RxValid   = 1'b0;
        StartLoad = 1'b0;
        checks++;
        if (RxReady !== 1'b1 || CpuHold !== 1'b1 || WordCount !== 16'd0 || wq_addr.size() != 0) begin
            failures++;
            $display("FAIL drop_restart rdy=%b hold=%b wc=%0d writes=%0d required 1/1/0/0", RxReady, CpuHold, WordCount, wq_addr.size());
        end
        send_byte(8'h00, int'($urandom_range(0, 7)));
        send_byte(8'h01, int'($urandom_range(0, 7)));
        send_word(32'h241A0001, int'($urandom_range(0, 7)));
        @(negedge clk);
        finish_load(8'hC1);
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 8'd0 || wq_data[0] !== 32'h241A0001 || LoadDone !== 1'b1) begin
            failures++;
            $display("FAIL gap_reload writes=%0d done=%b required 1 write 00/241a0001, done 1", wq_addr.size(), LoadDone);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(32'hAAAAAAAA, 0);
        @(negedge clk);
        send_word(32'hBBBBBBBB, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({CpuHold, RxReady, RamWE, LoadDone, LoadError} !== 5'b11000 || WordCount !== 16'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b wc=%0d required 11000/0", {CpuHold, RxReady, RamWE, LoadDone, LoadError}, WordCount);
        end
        @(negedge clk);
        reset = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        CpuPC = 32'h0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h241A0001, 0);
        @(negedge clk);
        finish_load(8'hC1);
        #1;
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 8'd0 || LoadDone !== 1'b1 || Instruction !== 32'h241A0001) begin
            failures++;
            $display("FAIL post_reset_load writes=%0d done=%b instr=%h required 1/1/241a0001", wq_addr.size(), LoadDone, Instruction);
        end
        @(negedge clk);
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum_bad();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h241A0001, 0);
        @(negedge clk);
        send_byte(8'h00, 0);
        checks++;
        if (LoadError !== 1'b1 || LoadDone !== 1'b0 || CpuHold !== 1'b1) begin
            failures++;
            $display("FAIL checksum_bad err=%b done=%b hold=%b required 1/0/1", LoadError, LoadDone, CpuHold);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        RxData    = 8'h00;
        RxValid   = 1'b0;
        StartLoad = 1'b0;
        CpuPC     = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_single_word();
        test_multi_word();
        test_oversize_header();
        test_gaps_and_drop();
        test_async_reset();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
